cnt_phase_sequencer: RTL and testbench

- Programmable scheduler that drives a shared small counter through a run of up to NPH counting phases.
- Each phase is stored in a config table: a mode (WRAP modulo-(LIMIT+1), or BOUNCE 0→LIMIT→0 up/down) plus a repeat count.
- A global prescaler sets the tick rate. Start/stop control, a busy flag and a done pulse let an upstream controller sequence runs.

---
 rtl/cnt_phase_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_cnt_phase_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_phase_sequencer.sv
// Phase-table driven counter sequencer: runs a shared counter through
// up to NPH WRAP/BOUNCE phases at a prescaled tick rate.
module cnt_phase_sequencer #(
   parameter int W   = 3,
   parameter int NPH = 4,
   parameter int PW  = 2,
   parameter int RW  = 4,
   parameter int DW  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [PW-1:0] cfg_addr,
   input  logic          cfg_mode,
   input  logic [W-1:0]  cfg_limit,
   input  logic [RW-1:0] cfg_reps,
   input  logic [PW-1:0] nph,
   input  logic [DW-1:0] div,
   input  logic          start,
   input  logic          stop,
   output logic [W-1:0]  cnt,
   output logic [PW-1:0] phase,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   state_t        r_state;
   logic [W-1:0]  r_cnt;
   logic [PW-1:0] r_phase;
   logic [DW-1:0] r_pre;
   logic [RW-1:0] r_rep;
   logic          r_dir;
   logic [PW-1:0] r_nph;
   logic [DW-1:0] r_div;

   logic          r_mode  [NPH];
   logic [W-1:0]  r_limit [NPH];
   logic [RW-1:0] r_reps  [NPH];

   state_t        w_state;
   logic [W-1:0]  w_cnt;
   logic [PW-1:0] w_phase;
   logic [DW-1:0] w_pre;
   logic [RW-1:0] w_rep;
   logic          w_dir;
   logic [PW-1:0] w_nph;
   logic [DW-1:0] w_div;
   logic          w_rep_done;
   logic          w_mode;
   logic [W-1:0]  w_lim;
   logic [RW-1:0] w_reps;
   logic          w_cfg_wr;

   assign w_mode   = r_mode[r_phase];
   assign w_lim    = r_limit[r_phase];
   assign w_reps   = r_reps[r_phase];
   assign w_cfg_wr = (r_state == S_IDLE) && cfg_we;

   always_comb begin
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_phase    = r_phase;
      w_pre      = r_pre;
      w_rep      = r_rep;
      w_dir      = r_dir;
      w_nph      = r_nph;
      w_div      = r_div;
      w_rep_done = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state = S_RUN;
               w_nph   = nph;
               w_div   = div;
               w_cnt   = '0;
               w_phase = '0;
               w_rep   = '0;
               w_pre   = '0;
               w_dir   = DIR_UP;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state = S_IDLE;
               w_cnt   = '0;
               w_phase = '0;
            end else if (r_pre == r_div) begin
               w_pre = '0;
               if (!w_mode) begin
                  if (r_cnt == w_lim) begin
                     w_cnt      = '0;
                     w_rep_done = 1'b1;
                  end else begin
                     w_cnt = r_cnt + 1'b1;
                  end
               end else if (r_dir == DIR_UP) begin
                  if (r_cnt < w_lim) begin
                     w_cnt = r_cnt + 1'b1;
                  end else if (w_lim >= W'(2)) begin
                     w_cnt = r_cnt - 1'b1;
                     w_dir = DIR_DN;
                  end else begin
                     w_cnt      = '0;
                     w_rep_done = 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt - 1'b1;
                  if (r_cnt == W'(1)) begin
                     w_dir      = DIR_UP;
                     w_rep_done = 1'b1;
                  end
               end
               // last rep of a phase either advances or ends the run
               if (w_rep_done) begin
                  if (r_rep == w_reps) begin
                     w_rep = '0;
                     w_dir = DIR_UP;
                     if (r_phase == r_nph) begin
                        w_state = S_DONE;
                     end else begin
                        w_phase = r_phase + 1'b1;
                     end
                  end else begin
                     w_rep = r_rep + 1'b1;
                  end
               end
            end else begin
               w_pre = r_pre + 1'b1;
            end
         end
         S_DONE: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_phase <= '0;
         r_pre   <= '0;
         r_rep   <= '0;
         r_dir   <= DIR_UP;
         r_nph   <= '0;
         r_div   <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_phase <= w_phase;
         r_pre   <= w_pre;
         r_rep   <= w_rep;
         r_dir   <= w_dir;
         r_nph   <= w_nph;
         r_div   <= w_div;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NPH; i++) begin
            r_mode[i]  <= 1'b0;
            r_limit[i] <= '0;
            r_reps[i]  <= '0;
         end
      end else if (w_cfg_wr) begin
         r_mode[cfg_addr]  <= cfg_mode;
         r_limit[cfg_addr] <= cfg_limit;
         r_reps[cfg_addr]  <= cfg_reps;
      end
   end

   assign cnt   = r_cnt;
   assign phase = r_phase;
   assign busy  = (r_state == S_RUN);
   assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_cnt_phase_sequencer.sv
// Randomized scoreboard bench for cnt_phase_sequencer; expected traces are
// built per run from the phase table as plain count sequences.
module tb_cnt_phase_sequencer;

   localparam int W   = 3;
   localparam int NPH = 4;
   localparam int PW  = 2;
   localparam int RW  = 4;
   localparam int DW  = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          cfg_we = 1'b0;
   logic [PW-1:0] cfg_addr = '0;
   logic          cfg_mode = 1'b0;
   logic [W-1:0]  cfg_limit = '0;
   logic [RW-1:0] cfg_reps = '0;
   logic [PW-1:0] nph = '0;
   logic [DW-1:0] div = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic [W-1:0]  cnt;
   logic [PW-1:0] phase;
   logic          busy;
   logic          done;

   cnt_phase_sequencer #(
      .W(W), .NPH(NPH), .PW(PW), .RW(RW), .DW(DW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_mode(cfg_mode), .cfg_limit(cfg_limit), .cfg_reps(cfg_reps),
      .nph(nph), .div(div), .start(start), .stop(stop),
      .cnt(cnt), .phase(phase), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0]  c;
      logic [PW-1:0] p;
      logic          b;
      logic          d;
   } obs_t;

   obs_t sb_q[$];
   obs_t tr_q[$];
   obs_t last_exp = '0;
   int   m_mode [NPH];
   int   m_lim  [NPH];
   int   m_reps [NPH];
   int   idle_ph = 0;
   int   n_chk = 0;
   int   n_err = 0;
   int   n_cyc = 0;
   int   wk = 0;

   function automatic obs_t mk(int c, int p, bit b, bit d);
      obs_t o;
      o.c = W'(c);
      o.p = PW'(p);
      o.b = b;
      o.d = d;
      return o;
   endfunction

   // Whole-run trace: one entry per clock edge from the start edge on.
   task automatic build_trace(input int n, input int dv);
      int cc = 0;
      int cp = 0;
      tr_q.delete();
      tr_q.push_back(mk(0, 0, 1, 0));
      for (int p = 0; p <= n; p++) begin
         int seq[$];
         int lim = m_lim[p];
         if (lim == 0) seq.push_back(0);
         else begin
            for (int v = 1; v <= lim; v++) seq.push_back(v);
            if (m_mode[p] == 0) seq.push_back(0);
            else for (int v = lim - 1; v >= 0; v--) seq.push_back(v);
         end
         for (int r = 0; r <= m_reps[p]; r++) begin
            for (int k = 0; k < seq.size(); k++) begin
               bit last;
               repeat (dv) tr_q.push_back(mk(cc, cp, 1, 0));
               cc = seq[k];
               last = (k == seq.size() - 1) && (r == m_reps[p]);
               if (last && p == n) tr_q.push_back(mk(0, p, 0, 1));
               else begin
                  if (last) cp = p + 1;
                  tr_q.push_back(mk(cc, cp, 1, 0));
               end
            end
         end
      end
      tr_q.push_back(mk(0, n, 0, 0));
      idle_ph = n;
   endtask

   task automatic cyc(input bit r, input bit we, input int a, input bit md,
                      input int l, input int rp, input int n, input int dv,
                      input bit s, input bit sp);
      obs_t e;
      @(negedge clk);
      rst = r; cfg_we = we; cfg_addr = PW'(a); cfg_mode = md;
      cfg_limit = W'(l); cfg_reps = RW'(rp); nph = PW'(n);
      div = DW'(dv); start = s; stop = sp;
      if (r) begin
         for (int i = 0; i < NPH; i++) begin
            m_mode[i] = 0; m_lim[i] = 0; m_reps[i] = 0;
         end
         tr_q.delete();
         idle_ph = 0;
         e = mk(0, 0, 0, 0);
      end else if (tr_q.size() > 0) begin
         if (sp && last_exp.b) begin
            tr_q.delete();
            idle_ph = 0;
            e = mk(0, 0, 0, 0);
         end else begin
            e = tr_q.pop_front();
         end
      end else begin
         if (we) begin
            m_mode[a] = md; m_lim[a] = l; m_reps[a] = rp;
         end
         if (s && !sp) begin
            build_trace(n, dv);
            e = tr_q.pop_front();
         end else begin
            e = mk(0, idle_ph, 0, 0);
         end
      end
      last_exp = e;
      sb_q.push_back(e);
   endtask

   task automatic idle(input int k);
      repeat (k) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic wr(input int a, input bit md, input int l, input int rp);
      cyc(0, 1, a, md, l, rp, 0, 0, 0, 0);
   endtask

   task automatic go(input int n, input int dv);
      cyc(0, 0, 0, 0, 0, 0, n, dv, 1, 0);
   endtask

   always @(posedge clk) begin
      obs_t e;
      obs_t g;
      #1;
      n_cyc++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         g = {cnt, phase, busy, done};
         n_chk++;
         if (g !== e) begin
            n_err++;
            $display("FAIL out@cyc%0d got cnt=%0d ph=%0d busy=%b done=%b want cnt=%0d ph=%0d busy=%b done=%b",
                     n_cyc, g.c, g.p, g.b, g.d, e.c, e.p, e.b, e.d);
         end
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      n_chk++;
      if ({cnt, phase, busy, done} !== '0) begin
         n_err++;
         $display("FAIL reset state cnt=%0d ph=%0d busy=%b done=%b",
                  cnt, phase, busy, done);
      end
      wr(0, 0, 2, 1);
      go(0, 0);
      wk = 0;
      while (done !== 1'b1 && wk < 20) begin
         idle(1);
         wk++;
      end
      n_chk++;
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL wait for done expired after %0d cycles", wk);
      end
      idle(3);
      wr(0, 1, 3, 0);
      go(0, 1);
      idle(15);
      wr(0, 0, 1, 0);
      wr(1, 1, 2, 0);
      go(1, 0);
      idle(9);
      wr(0, 0, 5, 3);
      go(0, 0);
      idle(2);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(3);
      go(0, 0);
      idle(4);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      idle(3);
      wr(0, 0, 2, 0);
      go(0, 0);
      cyc(0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 7, 0, 0, 0, 0, 0);
      idle(4);
      cyc(0, 1, 0, 0, 0, 2, 0, 0, 1, 0);
      idle(6);
      wr(0, 1, 5, 3);
      go(0, 2);
      idle(4);
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      go(0, 0);
      idle(4);
      for (int i = 0; i < 2500; i++) begin
         bit r  = ($urandom_range(0, 299) == 0);
         bit we = ($urandom_range(0, 2) == 0);
         bit s  = ($urandom_range(0, 3) == 0);
         bit sp = ($urandom_range(0, 39) == 0);
         cyc(r, we, $urandom_range(0, NPH - 1), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), $urandom_range(0, 3),
             $urandom_range(0, NPH - 1), $urandom_range(0, 2), s, sp);
      end
      idle(2);
      @(negedge clk);
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
